// File: rtl/nmi_sram_if.sv
// nmi_if: NMI request/response bundle between a core master and a fabric slave.
interface nmi_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_sram_resp.sv
// nmi_sram_resp: NMI slave mapping a BASE_ADDR window onto a single-port synchronous SRAM.
module nmi_sram_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 10,
  parameter int          RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  nmi_if.slave                  nmi,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i,
  output logic                  err_o
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPT, RESP} state_t;
  localparam logic [31:0] WIN_MASK  = ~((32'd4 << ADDR_WIDTH) - 32'd1);
  localparam logic [1:0]  WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
  state_t r_state, w_next;
  logic w_in_win, w_accept;
  logic r_wr, r_err, r_capt, r_cs, r_we, r_ready, r_err_o;
  logic [1:0] r_cnt;
  logic [3:0] r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0] r_wdata, r_rdata;
  assign w_in_win = (nmi.addr & WIN_MASK) == BASE_ADDR;
  assign w_accept = (r_state == IDLE) && nmi.valid;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = nmi.valid ? (w_in_win ? ACCESS : RESP) : IDLE;
      ACCESS:  w_next = r_wr ? RESP : ((RD_LAT > 1) ? WAIT : CAPT);
      WAIT:    w_next = (r_cnt == 2'd0) ? CAPT : WAIT;
      CAPT:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Strobes are registered off the state, so each lands one cycle after its state;
  // r_capt delays the capture to match the SRAM data window of the delayed cs.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_capt  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b0;
      r_err_o <= 1'b0;
      r_cnt   <= 2'd0;
      r_be    <= 4'h0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_cs    <= r_state == ACCESS;
      r_we    <= (r_state == ACCESS) && r_wr;
      r_ready <= r_state == RESP;
      r_err_o <= (r_state == RESP) && r_err;
      r_capt  <= r_state == CAPT;
      if (r_state == ACCESS) r_cnt <= WAIT_LOAD;
      else if (r_state == WAIT) r_cnt <= r_cnt - 2'd1;
      if (r_capt) r_rdata <= sram_rdata_i;
      else if ((r_state == RESP) && r_err && !r_wr) r_rdata <= 32'h0;
      if (w_accept) begin
        r_wr  <= |nmi.wstrb;
        r_err <= !w_in_win;
      end
      if (w_accept && w_in_win) begin
        r_addr  <= nmi.addr[ADDR_WIDTH+1:2];
        r_wdata <= nmi.wdata;
        r_be    <= (|nmi.wstrb) ? nmi.wstrb : 4'hF;
      end
    end
  assign sram_cs_o    = r_cs;
  assign sram_we_o    = r_we;
  assign sram_be_o    = r_be;
  assign sram_addr_o  = r_addr;
  assign sram_wdata_o = r_wdata;
  assign err_o        = r_err_o;
  assign nmi.ready    = r_ready;
  assign nmi.rdata    = r_rdata;
endmodule

// File: tb/tb_nmi_sram_resp.sv
// tb_nmi_sram_resp: scoreboard bench for two responders (RD_LAT=3 as dut 0, RD_LAT=1 as dut 1).
module tb_nmi_sram_resp;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  nmi_if ifa ();
  nmi_if ifb ();
  logic        valid = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  int          sel = 0;
  assign ifa.valid = valid && (sel == 0);
  assign ifb.valid = valid && (sel == 1);
  assign ifa.addr  = addr;
  assign ifb.addr  = addr;
  assign ifa.wdata = wdata;
  assign ifb.wdata = wdata;
  assign ifa.wstrb = wstrb;
  assign ifb.wstrb = wstrb;
  logic [1:0]        cs, we, err;
  logic [1:0][3:0]   be;
  logic [1:0][9:0]   sa;
  logic [1:0][31:0]  swd, srd;
  nmi_sram_resp #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .RD_LAT(3)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .nmi(ifa), .sram_cs_o(cs[0]), .sram_we_o(we[0]),
    .sram_be_o(be[0]), .sram_addr_o(sa[0]), .sram_wdata_o(swd[0]), .sram_rdata_i(srd[0]),
    .err_o(err[0]));
  nmi_sram_resp #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .RD_LAT(1)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .nmi(ifb), .sram_cs_o(cs[1]), .sram_we_o(we[1]),
    .sram_be_o(be[1]), .sram_addr_o(sa[1]), .sram_wdata_o(swd[1]), .sram_rdata_i(srd[1]),
    .err_o(err[1]));
  // SRAM models: read data is only meaningful in its latency slot, DEADBEEF elsewhere
  logic [31:0] mem [2][1024];
  logic [1:0][3:0][31:0] pd = '0;
  logic [1:0][3:0]       pv = '0;
  initial for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) mem[d][i] = 32'h0;
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (cs[d] && we[d])
        for (int b = 0; b < 4; b++) if (be[d][b]) mem[d][sa[d]][8*b+:8] <= swd[d][8*b+:8];
      pv[d] <= {pv[d][2:0], cs[d] && !we[d]};
      pd[d] <= {pd[d][2:0], mem[d][sa[d]]};
    end
  assign srd[0] = pv[0][2] ? pd[0][2] : 32'hDEAD_BEEF;
  assign srd[1] = pv[1][0] ? pd[1][0] : 32'hDEAD_BEEF;
  typedef struct {int d; int cyc; logic [31:0] rd; logic er;} resp_t;
  typedef struct {int d; int cyc; logic we; logic [3:0] be; logic [9:0] a; logic [31:0] wd;} acc_t;
  resp_t rq[$];
  acc_t  aq[$];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  function automatic int rl(input int d);
    return d == 0 ? 3 : 1;
  endfunction
  function automatic logic rdy(input int d);
    return d == 0 ? ifa.ready : ifb.ready;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return d == 0 ? ifa.rdata : ifb.rdata;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  // Monitor: pops expectations whenever a responder shows ready, cs or err
  always @(negedge clk)
    if (rst_n)
      for (int d = 0; d < 2; d++) begin
        if (rdy(d)) begin
          if (rq.size() == 0) chk("spurious_ready", {31'h0, rdy(d)}, 32'h0);
          else begin
            resp_t e;
            e = rq.pop_front();
            chk("resp_dut", d, e.d);
            chk("resp_cycle", cyc, e.cyc);
            chk("rdata", rdat(d), e.rd);
            chk("err_o", {31'h0, err[d]}, {31'h0, e.er});
          end
        end else if (err[d]) chk("spurious_err", {31'h0, err[d]}, 32'h0);
        if (cs[d]) begin
          if (aq.size() == 0) chk("spurious_cs", {31'h0, cs[d]}, 32'h0);
          else begin
            acc_t x;
            x = aq.pop_front();
            chk("cs_dut", d, x.d);
            chk("cs_cycle", cyc, x.cyc);
            chk("sram_we", {31'h0, we[d]}, {31'h0, x.we});
            chk("sram_be", {28'h0, be[d]}, {28'h0, x.be});
            chk("sram_addr", {22'h0, sa[d]}, {22'h0, x.a});
            if (x.we) chk("sram_wdata", swd[d], x.wd);
          end
        end
      end
  task automatic wait_ready(input int d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = rdy(d);
    end
    chk("ready_timeout", {31'h0, got}, 32'h1);
  endtask
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp, input bit hold);
    bit inw;
    int lat;
    logic [31:0] er;
    inw = (a >= BASE) && (a <= BASE + 32'hFFF);
    lat = !inw ? 1 : (ws != 4'h0 ? 2 : 2 + rl(d));
    er  = (ws != 4'h0) ? last_rd[d] : (inw ? exp : 32'h0);
    last_rd[d] = er;
    sel = d; addr = a; wdata = wd; wstrb = ws; valid = 1'b1;
    rq.push_back('{d, cyc + 1 + lat, er, !inw});
    if (inw) aq.push_back('{d, cyc + 2, ws != 4'h0, ws != 4'h0 ? ws : 4'hF, a[11:2], wd});
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
    end
    wait_ready(d);
  endtask
  task automatic idle_outputs(input int d, input string n);
    chk({n, "_ready"}, {31'h0, rdy(d)}, 32'h0);
    chk({n, "_cs"}, {31'h0, cs[d]}, 32'h0);
    chk({n, "_err"}, {31'h0, err[d]}, 32'h0);
    chk({n, "_rdata"}, rdat(d), 32'h0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      idle_outputs(d, "reset");
      chk("reset_be", {28'h0, be[d]}, 32'h0);
      chk("reset_addr", {22'h0, sa[d]}, 32'h0);
      chk("reset_we", {31'h0, we[d]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, BASE + 32'h10, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0);
    issue(0, BASE + 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0);
    issue(1, BASE + 32'h10, 32'hA5A5_1234, 4'hF, 32'h0, 1'b0);
    issue(1, BASE + 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0);
    issue(0, BASE + 32'h10, 32'h00CC_0000, 4'b0100, 32'h0, 1'b0);
    issue(0, BASE + 32'h10, 32'h0, 4'h0, 32'hA5CC_1234, 1'b0);
    issue(0, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(0, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    issue(0, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    issue(0, BASE + 32'h10, 32'h0, 4'h0, 32'hA5CC_1234, 1'b0);
    issue(0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    issue(0, BASE + 32'hFFF, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    issue(1, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(0, BASE + 32'h20, 32'h1111_2222, 4'hF, 32'h0, 1'b1);
    issue(0, BASE + 32'h20, 32'h0, 4'h0, 32'h1111_2222, 1'b0);
    issue(1, BASE + 32'h24, 32'h3333_4444, 4'h3, 32'h0, 1'b1);
    issue(1, BASE + 32'h24, 32'h0, 4'h0, 32'h0000_4444, 1'b0);
    // Reset while dut 0 sits in WAIT on a read
    sel = 0; addr = BASE + 32'h10; wdata = 32'h0; wstrb = 4'h0; valid = 1'b1;
    aq.push_back('{0, cyc + 2, 1'b0, 4'hF, 10'h4, 32'h0});
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 idle_outputs(0, "abort");
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(negedge clk);
    idle_outputs(0, "abort_next");
    idle_outputs(1, "abort_other");
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, BASE + 32'h10, 32'h0, 4'h0, 32'hA5CC_1234, 1'b0);
    issue(1, BASE + 32'h10, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0);
    repeat (10) @(negedge clk);
    chk("resp_queue_drained", rq.size(), 32'h0);
    chk("access_queue_drained", aq.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
